// File: rtl/wb_fifo_access_port.sv
// Wishbone FIFO window: a push/pop data register and a flag/status register.
// A single-cycle ACK follows each strobed access, and every side effect lands
// on the same edge that raises ACK.
module wb_fifo_access_port #(
  parameter int                   ADDRWIDTH        = 9,
  parameter int                   DATAWIDTH        = 32,
  parameter int                   FIFO_DEPTH       = 16,
  parameter logic [ADDRWIDTH-1:0] FIFO_ACC_ADR     = 9'h40,
  parameter logic [ADDRWIDTH-1:0] FIFO_FLAG_ADR    = 9'h41,
  parameter logic [DATAWIDTH-1:0] EMPTY_READ_VALUE = 32'hF1F0_E3E3,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE    = 32'hFAB_DEF_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic                 WBs_WE_i,
  input  logic                 WBs_RD_i,
  input  logic                 WBs_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic [7:0]           FIFO_Level_o,
  output logic                 FIFO_Empty_o,
  output logic                 FIFO_Full_o,
  output logic                 FIFO_Ovf_o,
  output logic                 FIFO_Udf_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Storage; not reset so it maps onto distributed/block RAM.
  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wptr_reg, rptr_reg;
  logic          ack_reg;
  logic          ovf_reg, udf_reg;
  logic [DATAWIDTH-1:0] dat_reg;

  logic [PW-1:0] level_diff;
  logic          empty, full;
  logic          req, acc_sel, flag_sel, any_be;
  logic          push, ovf_set, pop, udf_set, flag_wr;
  logic [DATAWIDTH-1:0] status_word;

  // RD_i is informational; it does not take part in the decode.
  logic unused_rd;
  assign unused_rd = WBs_RD_i;

  assign level_diff = wptr_reg - rptr_reg;
  assign empty      = (wptr_reg == rptr_reg);
  assign full       = (wptr_reg[AW] != rptr_reg[AW]) &&
                      (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);

  // ACK masks the strobe for one cycle, so back-to-back cycles ack every other clock.
  assign req      = WBs_CYC_i & WBs_STB_i & ~ack_reg;
  assign acc_sel  = (WBs_ADR_i == FIFO_ACC_ADR);
  assign flag_sel = (WBs_ADR_i == FIFO_FLAG_ADR);
  assign any_be   = |WBs_BYTE_STB_i;

  assign push    = req &  WBs_WE_i & acc_sel & any_be & ~full;
  assign ovf_set = req &  WBs_WE_i & acc_sel & any_be &  full;
  assign pop     = req & ~WBs_WE_i & acc_sel & ~empty;
  assign udf_set = req & ~WBs_WE_i & acc_sel &  empty;
  assign flag_wr = req &  WBs_WE_i & flag_sel & WBs_BYTE_STB_i[0];

  // Status register image: flags in the low nibble, level in bits 15:8.
  always_comb begin
    status_word       = '0;
    status_word[0]    = empty;
    status_word[1]    = full;
    status_word[2]    = ovf_reg;
    status_word[3]    = udf_reg;
    status_word[15:8] = 8'(level_diff);
  end

  // Data write port: only a non-full push writes the array.
  always_ff @(posedge WBs_CLK_i) begin
    if (push) begin
      mem[wptr_reg[AW-1:0]] <= WBs_DAT_i;
    end
  end

  // Bus handshake, pointers, sticky flags and registered read data.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ack_reg  <= 1'b0;
      dat_reg  <= '0;
      wptr_reg <= '0;
      rptr_reg <= '0;
      ovf_reg  <= 1'b0;
      udf_reg  <= 1'b0;
    end else begin
      ack_reg <= req;

      if (push) begin
        wptr_reg <= wptr_reg + PTR_ONE;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + PTR_ONE;
      end

      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (flag_wr && WBs_DAT_i[2]) begin
        ovf_reg <= 1'b0;
      end

      if (udf_set) begin
        udf_reg <= 1'b1;
      end else if (flag_wr && WBs_DAT_i[3]) begin
        udf_reg <= 1'b0;
      end

      // Read data is captured only on a read access and held otherwise.
      if (req && !WBs_WE_i) begin
        if (acc_sel) begin
          dat_reg <= empty ? EMPTY_READ_VALUE : mem[rptr_reg[AW-1:0]];
        end else if (flag_sel) begin
          dat_reg <= status_word;
        end else begin
          dat_reg <= DEF_REG_VALUE;
        end
      end
    end
  end

  assign WBs_ACK_o    = ack_reg;
  assign WBs_DAT_o    = dat_reg;
  assign FIFO_Level_o = 8'(level_diff);
  assign FIFO_Empty_o = empty;
  assign FIFO_Full_o  = full;
  assign FIFO_Ovf_o   = ovf_reg;
  assign FIFO_Udf_o   = udf_reg;

endmodule
